// File: rtl/mlp_layer2_mac.sv
// Output-layer MAC engine: one hidden activation x weight per cycle, one saturated Q8.8 score per neuron.
// Define MLP_L2_ARGMAX_EN to build the running-argmax classifier on class_idx/class_valid.
module mlp_layer2_mac #(
  parameter int N_IN   = 100,
  parameter int N_OUT  = 10,
  parameter int ACT_AW = 7,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ACT_AW-1:0]        act_addr,
  input  logic signed [15:0]       act_data,
  output logic [13:0]              wt_addr,
  input  logic signed [15:0]       wt_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_idx,
  output logic signed [15:0]       out_score,
  output logic [3:0]               class_idx,
  output logic                     class_valid
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_EMIT, S_DONE} state_t;

  localparam logic [ACT_AW-1:0]        LAST_I  = ACT_AW'(N_IN - 1);
  localparam logic [3:0]               LAST_O  = 4'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(-32'sd32768);

  state_t                    r_state, w_next;
  logic [ACT_AW-1:0]         r_i;
  logic [3:0]                r_o;
  logic [13:0]               r_wt_addr;
  logic signed [31:0]        r_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_busy, r_done, r_out_valid;
  logic [3:0]                r_out_idx;
  logic signed [15:0]        r_out_score;

  logic signed [31:0]        w_prod;
  logic signed [ACC_W-1:0]   w_acc_sum, w_shift;
  logic signed [15:0]        w_sat;
  logic                      w_hs;

  assign w_prod    = act_data * wt_data;
  assign w_acc_sum = r_acc + {{(ACC_W-32){r_prod[31]}}, r_prod};
  assign w_shift   = w_acc_sum >>> FRAC;
  assign w_hs      = (r_state == S_EMIT) && r_out_valid && out_ready;

  // Clamp the rescaled accumulator into the 16-bit score range
  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > SAT_MAX) begin
      w_sat = 16'sh7FFF;
    end else if (w_shift < SAT_MIN) begin
      w_sat = 16'sh8000;
    end else begin
      w_sat = w_shift[15:0];
    end
  end

  // Next-state decode for the per-neuron MAC sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_MAC; else w_next = S_IDLE;
      S_MAC:   if (r_i == LAST_I) w_next = S_DRAIN; else w_next = S_MAC;
      S_DRAIN: w_next = S_EMIT;
      S_EMIT: begin
        if (w_hs) begin
          if (r_o == LAST_O) w_next = S_DONE; else w_next = S_MAC;
        end else begin
          w_next = S_EMIT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, counters and registered outputs; r_prod is cleared so the first MAC cycle adds zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_o         <= 4'd0;
      r_wt_addr   <= 14'd0;
      r_prod      <= 32'sd0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= 4'd0;
      r_out_score <= 16'sd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i       <= '0;
            r_o       <= 4'd0;
            r_wt_addr <= 14'd0;
            r_prod    <= 32'sd0;
            r_acc     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_MAC: begin
          r_prod <= w_prod;
          r_acc  <= w_acc_sum;
          if (r_i != LAST_I) begin
            r_i       <= r_i + ACT_AW'(1'b1);
            r_wt_addr <= r_wt_addr + 14'd1;
          end
        end
        S_DRAIN: begin
          r_acc       <= w_acc_sum;
          r_out_score <= w_sat;
          r_out_idx   <= r_o;
          r_out_valid <= 1'b1;
        end
        S_EMIT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_prod      <= 32'sd0;
            r_i         <= '0;
            if (r_o == LAST_O) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_o       <= r_o + 4'd1;
              r_wt_addr <= r_wt_addr + 14'd1;
            end
          end
        end
        S_DONE:  r_done <= 1'b0;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign act_addr  = r_i;
  assign wt_addr   = r_wt_addr;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_score = r_out_score;

`ifdef MLP_L2_ARGMAX_EN
  logic signed [15:0] r_max;
  logic [3:0]         r_max_idx, r_class_idx;
  logic               r_class_valid;
  logic               w_new_max;

  // Strictly-greater keeps the lowest index on ties
  assign w_new_max = (r_o == 4'd0) || (r_out_score > r_max);

  // Running maximum over the scores of one pass, published with done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_max         <= 16'sd0;
      r_max_idx     <= 4'd0;
      r_class_idx   <= 4'd0;
      r_class_valid <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_class_valid <= 1'b0;
    end else if (w_hs) begin
      if (w_new_max) begin
        r_max     <= r_out_score;
        r_max_idx <= r_o;
      end
      if (r_o == LAST_O) begin
        r_class_idx   <= w_new_max ? r_o : r_max_idx;
        r_class_valid <= 1'b1;
      end
    end
  end

  assign class_idx   = r_class_idx;
  assign class_valid = r_class_valid;
`else
  assign class_idx   = 4'd0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: doc/mlp_layer2_mac.md
Name: mlp_layer2_mac

Overview:
- Sequential multiply-accumulate engine for the second (output) layer of the handwriting MLP.
- Reads hidden-layer activations from the activation buffer and layer-2 weights from the 14-bit-address weight ROM, one input per cycle.
- Forms one signed fixed-point score per output neuron and streams the scores downstream over a valid/ready handshake.
- Sits directly downstream of the layer-2 weight ROM and consumes its combinational read data.

Parameters:
- N_IN, 100, hidden activations per output neuron.
- N_OUT, 10, output neurons (digit classes).
- ACT_AW, 7, activation buffer address width; must satisfy 2^ACT_AW >= N_IN.
- FRAC, 8, fractional bits of the Q-format shared by activations, weights and scores.
- ACC_W, 40, accumulator width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a full layer pass.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse after the last score handshake.
- act_addr  out  ACT_AW  activation buffer read address.
- act_data  in  16  signed activation; combinational read of act_addr.
- wt_addr  out  14  weight ROM address.
- wt_data  in  16  signed weight; combinational read of wt_addr.
- out_valid  out  1  score available.
- out_ready  in  1  downstream accepts the score.
- out_idx  out  4  neuron index of out_score.
- out_score  out  16  signed saturated score.
- class_idx  out  4  argmax result (see Optional Feature).
- class_valid  out  1  class_idx valid (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state is sampled on the rising edge of clk while reset=1.
- Reset values: state IDLE; busy, done, out_valid, class_valid = 0; act_addr, wt_addr, out_idx, out_score, class_idx = 0; accumulator and counters = 0.
- Reset mid-operation: aborts the pass in the next cycle with no partial output and no done pulse.
- Weight layout is row-major: wt_addr = o*N_IN + i; act_addr = i.
- State machine: IDLE -> MAC -> DRAIN -> EMIT -> (MAC for the next neuron | DONE) -> IDLE.
- IDLE: start=1 moves to MAC with o=0, i=0, acc=0, busy=1. start is ignored in every other state.
- MAC, lasting N_IN cycles:
  - Drive addresses for input i.
  - Register prod_r = act_data*wt_data as a 32-bit signed value.
  - acc += prod_r from the previous cycle. The first MAC cycle adds nothing.
  - Increment i. After i = N_IN-1, go to DRAIN.
- DRAIN, 1 cycle:
  - acc += last prod_r.
  - Register out_score = sat16(acc >>> FRAC) using an arithmetic shift.
  - Set out_idx = o and out_valid = 1, then go to EMIT.
- sat16: values above 32767 clamp to 32767; values below -32768 clamp to -32768.
- EMIT:
  - Hold out_valid, out_idx and out_score stable until out_valid & out_ready.
  - On the handshake: out_valid = 0, acc = 0, i = 0.
  - If o = N_OUT-1, go to DONE; otherwise o += 1 and go to MAC.
- DONE, 1 cycle: done = 1, busy = 0, then return to IDLE. A start sampled in DONE is ignored.
- Latency with out_ready held high:
  - First out_valid appears N_IN+1 cycles after the start edge.
  - Each neuron takes N_IN+2 cycles.
  - done is high N_OUT*(N_IN+2) cycles after the start edge.
- Addresses never exceed N_OUT*N_IN-1 on wt_addr or N_IN-1 on act_addr. Addresses hold their last value outside MAC.

Optional Feature:
- Macro: MLP_L2_ARGMAX_EN.
- Defined:
  - Tracks the running maximum of out_score over each pass; a strictly-greater comparison means ties keep the lowest index.
  - In the DONE cycle, class_idx = index of the maximum and class_valid = 1.
  - class_valid clears on the next start accept or on reset. class_idx holds until the next DONE.
- Not defined: class_idx and class_valid are tied to 0 and no comparator logic is built.

Test Plan:
- All activations 0, arbitrary weights, out_ready=1 -> 10 scores of 0, out_idx 0..9 in order, done exactly 1020 cycles after the start edge.
- All activations 256 (1.0), all weights 256 -> every score = 25600 (100*1.0 in Q8.8).
- Activations 0x7FFF, weights 0x7FFF -> score 32767. Weights 0x8001 -> score -32768.
- out_ready held low 5 cycles on neuron 3 -> out_valid stays high, out_idx=3 and out_score unchanged, no address activity, neuron 4 starts only after the handshake.
- Reset asserted in MAC at i=40 of neuron 2 -> next cycle busy=0, out_valid=0, no done pulse; a later start runs a clean full pass.
- ARGMAX_EN set:
  - Weights make neuron 7 the largest -> class_idx=7, class_valid=1 in the done cycle.
  - Neurons 2 and 5 tied for the maximum -> class_idx=2.
